// File: rtl/sram_controller.sv
// sram_controller: memory-stage controller servicing one 32-bit load/store
// as two 16-bit phases (low then high halfword) on an asynchronous SRAM.
// Holds the pipeline with freeze while an access is in flight.
// Optional one-entry last-word read cache: define SRAM_LAST_WORD_CACHE_EN.
module sram_controller #(
    parameter int BASE_ADDR     = 1024,
    parameter int ACCESS_CYCLES = 2,
    parameter int SRAM_ADDR_W   = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   memREn,
    input  logic                   memWEn,
    input  logic [31:0]            address,
    input  logic [31:0]            writeData,
    output logic [31:0]            readData,
    output logic                   freeze,
    output logic [SRAM_ADDR_W-1:0] sramAddr,
    output logic [15:0]            sramDqOut,
    input  logic [15:0]            sramDqIn,
    output logic                   sramDqOe,
    output logic                   sramWeN
);

    localparam int CNT_W = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);
`ifdef SRAM_LAST_WORD_CACHE_EN
    localparam int IDX_W = 30;
`else
    localparam int IDX_W = SRAM_ADDR_W - 1;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic             lastPhase;
    logic             accept;
    logic             hit;
    logic             reqValid;
    logic [IDX_W-1:0] reqWordIdx;

    logic             opWrite;
    logic [IDX_W-1:0] wordIdx;
    logic [31:0]      wdLatch;

    assign reqValid   = memREn | memWEn;
    assign reqWordIdx = IDX_W'((address - 32'(BASE_ADDR)) >> 2);
    assign lastPhase  = (cnt == LAST_CNT);

`ifdef SRAM_LAST_WORD_CACHE_EN
    logic        cacheValid;
    logic [29:0] cacheTag;
    logic [31:0] cacheData;

    assign hit = memREn && !memWEn && cacheValid && (cacheTag == reqWordIdx);

    // Last-word cache: cleared by reset, filled/updated on every completed access
    always_ff @(posedge clk) begin
        if (rst) begin
            cacheValid <= 1'b0;
        end else if (state == DONE) begin
            cacheValid <= 1'b1;
            cacheTag   <= wordIdx;
            cacheData  <= opWrite ? wdLatch : readData;
        end
    end
`else
    assign hit = 1'b0;
`endif

    // State and phase counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Next-state logic and SRAM/pipeline control outputs
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        accept    = 1'b0;
        freeze    = 1'b0;
        sramAddr  = '0;
        sramDqOut = '0;
        sramDqOe  = 1'b0;
        sramWeN   = 1'b1;
        case (state)
            IDLE: begin
                if (reqValid && !hit) begin
                    freeze    = 1'b1;
                    accept    = 1'b1;
                    stateNext = LO;
                    cntNext   = '0;
                end
            end
            LO, HI: begin
                freeze   = 1'b1;
                sramAddr = {wordIdx[SRAM_ADDR_W-2:0], (state == HI)};
                if (opWrite) begin
                    sramDqOe  = 1'b1;
                    sramDqOut = (state == HI) ? wdLatch[31:16] : wdLatch[15:0];
                    // WE rises on the last phase cycle so data is held across the edge
                    sramWeN   = lastPhase;
                end
                if (lastPhase) begin
                    stateNext = (state == LO) ? HI : DONE;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Request latch and load result assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            opWrite  <= 1'b0;
            wordIdx  <= '0;
            wdLatch  <= '0;
            readData <= '0;
        end else begin
            if (accept) begin
                opWrite <= memWEn;
                wordIdx <= reqWordIdx;
                wdLatch <= writeData;
            end
            if (!opWrite && lastPhase) begin
                if (state == LO) readData[15:0]  <= sramDqIn;
                if (state == HI) readData[31:16] <= sramDqIn;
            end
`ifdef SRAM_LAST_WORD_CACHE_EN
            if (state == IDLE && hit) readData <= cacheData;
`endif
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Directed testbench for sram_controller with a behavioural async SRAM.
// Cache scenarios are compiled in when SRAM_LAST_WORD_CACHE_EN is defined.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        memREn, memWEn;
    logic [31:0] address, writeData, readData;
    logic        freeze;
    logic [17:0] sramAddr;
    logic [15:0] sramDqOut, sramDqIn;
    logic        sramDqOe, sramWeN;
    logic        memInit;

    logic [15:0] mem [0:255];
    logic [17:0] addrLog [0:19];
    logic        weLog   [0:19];
    logic        oeLog   [0:19];
    logic [15:0] dqLog   [0:19];

    int total = 0;
    int bad   = 0;

    sram_controller #(
        .BASE_ADDR(1024),
        .ACCESS_CYCLES(2),
        .SRAM_ADDR_W(18)
    ) dut (
        .clk(clk),
        .rst(rst),
        .memREn(memREn),
        .memWEn(memWEn),
        .address(address),
        .writeData(writeData),
        .readData(readData),
        .freeze(freeze),
        .sramAddr(sramAddr),
        .sramDqOut(sramDqOut),
        .sramDqIn(sramDqIn),
        .sramDqOe(sramDqOe),
        .sramWeN(sramWeN)
    );

    always #5 clk = ~clk;

    // SRAM model: initial pattern A000+i, write captured while WE is low
    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 + 16'(i);
        end else if (sramWeN === 1'b0) begin
            mem[sramAddr[7:0]] <= sramDqOut;
        end
    end

    assign sramDqIn = mem[sramAddr[7:0]];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, output int n, output int rdViol);
        memREn = rd; memWEn = wr; address = a; writeData = d;
        #1;
        n = 0; rdViol = 0;
        while (freeze === 1'b1 && n < 20) begin
            addrLog[n] = sramAddr; weLog[n] = sramWeN;
            oeLog[n] = sramDqOe;   dqLog[n] = sramDqOut;
            if (!wr && (sramDqOe !== 1'b0 || sramWeN !== 1'b1)) rdViol++;
            n++;
            tick;
            memREn = 1'b0; memWEn = 1'b0;
            address = 32'hFFFF_FFF0; writeData = 32'h0BAD_0BAD;
            #1;
        end
    endtask

    task automatic test_reset;
        total++; if (readData !== 32'h0) begin bad++; $display("FAIL por_readData got=%h exp=0", readData); end
        total++; if (freeze !== 1'b0) begin bad++; $display("FAIL por_freeze got=%b exp=0", freeze); end
        total++; if (sramWeN !== 1'b1 || sramDqOe !== 1'b0) begin bad++; $display("FAIL por_sram weN=%b oe=%b exp 1/0", sramWeN, sramDqOe); end
        total++; if (sramAddr !== 18'h0 || sramDqOut !== 16'h0) begin bad++; $display("FAIL por_bus addr=%h dq=%h exp 0/0", sramAddr, sramDqOut); end
        memREn = 1'b1; address = 32'd1036;
        tick; memREn = 1'b0;
        tick;
        tick;
        total++; if (readData !== 32'h0000_A006) begin bad++; $display("FAIL midread_lo got=%h exp=0000a006", readData); end
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        #1;
        total++; if (freeze !== 1'b0) begin bad++; $display("FAIL rst_freeze got=%b exp=0", freeze); end
        total++; if (sramWeN !== 1'b1 || sramDqOe !== 1'b0) begin bad++; $display("FAIL rst_sram weN=%b oe=%b exp 1/0", sramWeN, sramDqOe); end
        total++; if (readData !== 32'h0) begin bad++; $display("FAIL rst_readData got=%h exp=0", readData); end
        tick;
        total++; if (freeze !== 1'b0 || sramAddr !== 18'h0) begin bad++; $display("FAIL rst_idle freeze=%b addr=%h exp 0/0", freeze, sramAddr); end
    endtask

    task automatic test_store;
        int n, v;
        run_access(1'b0, 1'b1, 32'd1036, 32'hDEAD_BEEF, n, v);
        total++; if (n != 5) begin bad++; $display("FAIL store_freeze got=%0d exp=5", n); end
        total++; if (weLog[0] !== 1'b1) begin bad++; $display("FAIL store_idle_we got=%b exp=1", weLog[0]); end
        for (int i = 1; i <= 4; i++) begin
            logic [17:0] eA;
            logic        eWe;
            logic [15:0] eDq;
            eA  = (i <= 2) ? 18'd6 : 18'd7;
            eWe = (i == 2 || i == 4);
            eDq = (i <= 2) ? 16'hBEEF : 16'hDEAD;
            total++;
            if (addrLog[i] !== eA || weLog[i] !== eWe || dqLog[i] !== eDq || oeLog[i] !== 1'b1) begin
                bad++;
                $display("FAIL store_cyc%0d addr=%h we=%b dq=%h oe=%b exp %h/%b/%h/1",
                         i, addrLog[i], weLog[i], dqLog[i], oeLog[i], eA, eWe, eDq);
            end
        end
        total++; if (mem[6] !== 16'hBEEF || mem[7] !== 16'hDEAD) begin bad++; $display("FAIL store_mem got=%h_%h exp=dead_beef", mem[7], mem[6]); end
        total++; if (sramWeN !== 1'b1 || sramDqOe !== 1'b0 || readData !== 32'h0) begin bad++; $display("FAIL store_done weN=%b oe=%b rd=%h exp 1/0/0", sramWeN, sramDqOe, readData); end
        tick;
    endtask

    task automatic test_dual;
        int n, v;
        run_access(1'b1, 1'b1, 32'd1024, 32'h1234_5678, n, v);
        total++; if (n != 5) begin bad++; $display("FAIL dual_freeze got=%0d exp=5", n); end
        total++; if (mem[0] !== 16'h5678 || mem[1] !== 16'h1234) begin bad++; $display("FAIL dual_mem got=%h_%h exp=1234_5678", mem[1], mem[0]); end
        total++; if (readData !== 32'h0) begin bad++; $display("FAIL dual_readData got=%h exp=0", readData); end
        tick;
    endtask

    task automatic test_load;
        int n, v;
        run_access(1'b1, 1'b0, 32'd1036, 32'h0, n, v);
        total++; if (n != 5) begin bad++; $display("FAIL load_freeze got=%0d exp=5", n); end
        total++; if (v != 0) begin bad++; $display("FAIL load_oe_we violations=%0d exp=0", v); end
        total++; if (readData !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_data got=%h exp=deadbeef", readData); end
        tick;
    endtask

    task automatic test_back_to_back;
        int n1, n2, v;
        run_access(1'b1, 1'b0, 32'd1048, 32'h0, n1, v);
        total++; if (n1 != 5) begin bad++; $display("FAIL b2b_first_freeze got=%0d exp=5", n1); end
        total++; if (readData !== 32'hA00D_A00C) begin bad++; $display("FAIL b2b_load got=%h exp=a00da00c", readData); end
        total++; if (freeze !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b exp=0", freeze); end
        tick;
        run_access(1'b0, 1'b1, 32'd1052, 32'h55AA_33CC, n2, v);
        total++; if (n2 != 5) begin bad++; $display("FAIL b2b_second_freeze got=%0d exp=5", n2); end
        total++; if (mem[14] !== 16'h33CC || mem[15] !== 16'h55AA) begin bad++; $display("FAIL b2b_mem got=%h_%h exp=55aa_33cc", mem[15], mem[14]); end
        total++; if (readData !== 32'hA00D_A00C) begin bad++; $display("FAIL b2b_rd_kept got=%h exp=a00da00c", readData); end
        tick;
    endtask

`ifdef SRAM_LAST_WORD_CACHE_EN
    task automatic test_cache;
        int n, v;
        run_access(1'b0, 1'b1, 32'd1040, 32'hCAFE_0001, n, v);
        total++; if (n != 5) begin bad++; $display("FAIL cache_store_freeze got=%0d exp=5", n); end
        tick;
        memREn = 1'b1; address = 32'd1040;
        #1;
        total++; if (freeze !== 1'b0) begin bad++; $display("FAIL cache_hit_freeze got=%b exp=0", freeze); end
        tick;
        memREn = 1'b0;
        #1;
        total++; if (readData !== 32'hCAFE_0001) begin bad++; $display("FAIL cache_hit_data got=%h exp=cafe0001", readData); end
        total++; if (freeze !== 1'b0 || sramWeN !== 1'b1) begin bad++; $display("FAIL cache_hit_idle freeze=%b weN=%b exp 0/1", freeze, sramWeN); end
        run_access(1'b1, 1'b0, 32'd1044, 32'h0, n, v);
        total++; if (n != 5) begin bad++; $display("FAIL cache_miss_freeze got=%0d exp=5", n); end
        total++; if (readData !== 32'hA00B_A00A) begin bad++; $display("FAIL cache_miss_data got=%h exp=a00ba00a", readData); end
        tick;
    endtask
`else
    task automatic test_repeat_load;
        int n, v;
        run_access(1'b1, 1'b0, 32'd1048, 32'h0, n, v);
        total++; if (n != 5) begin bad++; $display("FAIL repeat_freeze got=%0d exp=5", n); end
        total++; if (readData !== 32'hA00D_A00C) begin bad++; $display("FAIL repeat_data got=%h exp=a00da00c", readData); end
        tick;
    endtask
`endif

    initial begin
        rst = 1'b1; memInit = 1'b1;
        memREn = 1'b0; memWEn = 1'b0; address = 32'h0; writeData = 32'h0;
        tick; tick; tick;
        memInit = 1'b0; rst = 1'b0;
        #1;
        test_reset;
        test_store;
        test_dual;
        test_load;
        test_back_to_back;
`ifdef SRAM_LAST_WORD_CACHE_EN
        test_cache;
`else
        test_repeat_load;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Memory-stage controller that services one 32-bit load/store from the pipeline using two 16-bit accesses to an external asynchronous SRAM.
- Sits between the EX-MEM pipeline register outputs and the WB stage.
- Drives the pipeline-wide freeze consumed by the IF, IF-ID, ID-EX and EX-MEM registers while an access is in flight.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM halfword 0.
- ACCESS_CYCLES, 2: cycles per 16-bit SRAM phase. Minimum is 2.
- SRAM_ADDR_W, 18: SRAM halfword address width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- memREn  input  1  load request from EX-MEM
- memWEn  input  1  store request from EX-MEM
- address  input  32  byte address (ALU result)
- writeData  input  32  store data (Rm value)
- readData  output  32  load result to WB
- freeze  output  1  stall for the whole pipeline
- sramAddr  output  SRAM_ADDR_W  SRAM halfword address
- sramDqOut  output  16  data driven to SRAM
- sramDqIn  input  16  data sampled from SRAM
- sramDqOe  output  1  1 = controller drives the DQ bus
- sramWeN  output  1  SRAM write enable, active low

Behaviour:
- Reset values: state IDLE; readData=0; sramAddr=0; sramDqOut=0; sramDqOe=0; sramWeN=1. Reset mid-access aborts immediately.
- Address mapping: wordIdx = (address - BASE_ADDR) >> 2. Low halfword address = {wordIdx,0}; high halfword address = {wordIdx,1}; both truncated to SRAM_ADDR_W. address[1:0] is ignored.
- States: IDLE, LO, HI, DONE. A phase counter runs 0..ACCESS_CYCLES-1 in LO and in HI.
- IDLE
  - If memREn|memWEn: freeze=1 combinationally in this same cycle; latch op (write if memWEn, else read), address and writeData; go to LO with counter=0.
  - If memREn and memWEn are both high, the access is a write.
  - Otherwise freeze=0 and stay in IDLE.
- LO
  - freeze=1; sramAddr = low halfword address.
  - Write op: sramDqOe=1, sramDqOut=writeData[15:0]. sramWeN=0 for counter < ACCESS_CYCLES-1 and 1 on the last cycle, so data is held across the WE rising edge.
  - Read op: sramDqOe=0, sramWeN=1. On the last cycle, readData[15:0] <= sramDqIn.
  - On the last cycle go to HI with counter=0.
- HI
  - Same as LO using the high halfword address and bits [31:16].
  - On the last cycle go to DONE.
- DONE
  - freeze=0, sramWeN=1, sramDqOe=0.
  - readData holds the full word; the pipeline advances on this edge.
  - Next state is IDLE unconditionally. A new request is accepted only in IDLE, so a single request is never serviced twice.
- Latency: freeze is high for 1 + 2*ACCESS_CYCLES consecutive cycles (5 at the default), then low for at least one cycle.
- Requests are latched at acceptance. Inputs that change or drop mid-access are ignored and the access completes.
- readData is unchanged by writes and is valid from the DONE cycle until the next read completes.
- sramDqOe and sramWeN are never asserted during a read or in IDLE.

Optional Feature:
- Macro: SRAM_LAST_WORD_CACHE_EN.
- When defined: a one-entry cache holds a valid bit, wordIdx and data.
  - A read in IDLE whose wordIdx matches a valid entry is a hit. On a hit: freeze stays 0, readData <= cached data at the clock edge, and the state stays IDLE.
  - Misses fill the entry at DONE.
  - Writes always run the full SRAM sequence and update the entry at DONE (write-through).
  - Reset clears the valid bit.
- When undefined: every read takes the full sequence and no cache storage exists.

Test Plan:
- Reset: assert rst for 2 cycles mid-read -> state IDLE, freeze=0, sramWeN=1, sramDqOe=0, readData=0.
- Store 0xDEADBEEF to 1036 -> sramAddr=6 with sramDqOut=0xBEEF and sramWeN low 1 cycle then high; then sramAddr=7 with 0xDEAD; freeze high exactly 5 cycles.
- Load from 1036 (SRAM model holds 0xBEEF@6, 0xDEAD@7) -> readData=0xDEADBEEF in the DONE cycle; freeze high 5 cycles; sramDqOe=0 throughout.
- Load from 1024 with memREn=memWEn=1, writeData=0x12345678 -> treated as a write: halfword 0=0x5678, halfword 1=0x1234; readData unchanged.
- Back-to-back: load, then a store presented in the cycle after DONE -> second access starts from IDLE; freeze pattern 5 high, 1 low, 5 high.
- With SRAM_LAST_WORD_CACHE_EN: store 0xCAFE0001 to 1040, then load 1040 -> load completes with freeze=0 and readData=0xCAFE0001; load 1044 -> miss, freeze high 5 cycles.
